// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM-stage access controller: the FSM state type
// and the bit positions of the WB and MEM control fields from EX/MEM.
package mem_stage_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;
    localparam int unsigned MEM_READ    = 1;
    localparam int unsigned MEM_WRITE   = 0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Every edge it captures the ALU result and the
// destination register. The WB controls are captured unless a bubble is
// requested, in which case they are zeroed. Load data is captured only on
// the memory load strobe.
module mem_wb_reg (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        i_bubble,
    input  logic        i_mem_ld,
    input  logic [1:0]  i_wb,
    input  logic [31:0] i_memdata,
    input  logic [31:0] i_result,
    input  logic [4:0]  i_writeaddr,
    output logic [1:0]  o_wb,
    output logic [31:0] o_memdata,
    output logic [31:0] o_result,
    output logic [4:0]  o_writeaddr
);

    logic [1:0]  r_wb;
    logic [31:0] r_memdata;
    logic [31:0] r_result;
    logic [4:0]  r_writeaddr;

    // Pipeline register with bubble insertion and a separate load-data enable
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wb        <= '0;
            r_memdata   <= '0;
            r_result    <= '0;
            r_writeaddr <= '0;
        end else begin
            r_wb        <= i_bubble ? 2'b00 : i_wb;
            r_result    <= i_result;
            r_writeaddr <= i_writeaddr;
            if (i_mem_ld) begin
                r_memdata <= i_memdata;
            end
        end
    end

    assign o_wb        = r_wb;
    assign o_memdata   = r_memdata;
    assign o_result    = r_result;
    assign o_writeaddr = r_writeaddr;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage access controller. Decodes EX/MEM memory controls, runs a
// req/ack handshake with a multi-cycle data memory, stalls the pipeline while
// the access is outstanding, and flags misaligned, illegal and timed-out
// accesses through a sticky error bit.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [1:0]  wb_i,
    input  logic [2:0]  mem_i,
    input  logic [31:0] result_i,
    input  logic [31:0] rtdata_i,
    input  logic [4:0]  writeaddr_i,
    input  logic        err_clr_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [1:0]  wb_o,
    output logic [31:0] memdata_o,
    output logic [31:0] result_o,
    output logic [4:0]  writeaddr_o,
    output logic        err_o
);

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0] r_cnt;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_err;

    logic w_rd;
    logic w_wr;
    logic w_access;
    logic w_illegal;
    logic w_misaligned;
    logic w_legal;
    logic w_timeout;

    logic w_stall;
    logic w_bubble;
    logic w_mem_ld;
    logic w_err_set;
    logic w_issue;

    // mem_i[2] is reserved and deliberately ignored
    logic w_unused;
    assign w_unused = mem_i[2];

    assign w_rd         = mem_i[MEM_READ];
    assign w_wr         = mem_i[MEM_WRITE];
    assign w_access     = w_rd ^ w_wr;
    assign w_illegal    = w_rd & w_wr;
    assign w_misaligned = w_access & (result_i[1:0] != 2'b00);
    assign w_legal      = w_access & ~w_misaligned;
    assign w_timeout    = (r_state == ACCESS) && !dmem_ack_i
                          && (r_cnt == CNT_W'(TIMEOUT - 1));

    // Next-state decode and per-cycle pipeline/handshake controls
    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_bubble  = 1'b0;
        w_mem_ld  = 1'b0;
        w_err_set = 1'b0;
        w_issue   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_legal) begin
                    w_next   = ACCESS;
                    w_stall  = 1'b1;
                    w_issue  = 1'b1;
                    w_bubble = 1'b1;
                end else if (w_illegal || w_misaligned) begin
                    w_err_set = 1'b1;
                    w_bubble  = 1'b1;
                end
            end
            ACCESS: begin
                // Ack takes priority over an expiring timeout in the same cycle
                if (dmem_ack_i) begin
                    w_next   = IDLE;
                    w_mem_ld = ~r_we;
                end else if (w_timeout) begin
                    w_next    = IDLE;
                    w_err_set = 1'b1;
                    w_bubble  = 1'b1;
                end else begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // FSM state, wait counter, request fields and sticky error
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_req   <= (w_next == ACCESS);
            if (w_issue) begin
                r_cnt   <= '0;
                r_we    <= w_wr;
                r_addr  <= result_i;
                r_wdata <= rtdata_i;
            end else if (r_state == ACCESS && w_next == ACCESS) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .i_bubble    (w_bubble),
        .i_mem_ld    (w_mem_ld),
        .i_wb        (wb_i),
        .i_memdata   (dmem_rdata_i),
        .i_result    (result_i),
        .i_writeaddr (writeaddr_i),
        .o_wb        (wb_o),
        .o_memdata   (memdata_o),
        .o_result    (result_o),
        .o_writeaddr (writeaddr_o)
    );

    // Stall is forced low while reset is asserted
    assign stall_o      = w_stall & rst_n_i;
    assign dmem_req_o   = r_req;
    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = r_addr;
    assign dmem_wdata_o = r_wdata;
    assign err_o        = r_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl, built with TIMEOUT=4.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  wb_i;
    logic [2:0]  mem_i;
    logic [31:0] result_i;
    logic [31:0] rtdata_i;
    logic [4:0]  writeaddr_i;
    logic        err_clr;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic [1:0]  wb_o;
    logic [31:0] memdata_o;
    logic [31:0] result_o;
    logic [4:0]  writeaddr_o;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .wb_i         (wb_i),
        .mem_i        (mem_i),
        .result_i     (result_i),
        .rtdata_i     (rtdata_i),
        .writeaddr_i  (writeaddr_i),
        .err_clr_i    (err_clr),
        .dmem_req_o   (req),
        .dmem_we_o    (we),
        .dmem_addr_o  (addr),
        .dmem_wdata_o (wdata),
        .dmem_ack_i   (ack),
        .dmem_rdata_i (rdata),
        .stall_o      (stall),
        .wb_o         (wb_o),
        .memdata_o    (memdata_o),
        .result_o     (result_o),
        .writeaddr_o  (writeaddr_o),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wb_i = 2'b11; mem_i = 3'b000; result_i = 32'h1;
        rtdata_i = 32'h2; writeaddr_i = 5'd1; err_clr = 1'b0; ack = 1'b0; rdata = '0;
        tick(); tick();
        n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", req); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_tests++; if ({wb_o, memdata_o, result_o, writeaddr_o, err, we, addr, wdata} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: wb=%b md=%h res=%h wa=%0d err=%b we=%b addr=%h wd=%h want all 0",
                              wb_o, memdata_o, result_o, writeaddr_o, err, we, addr, wdata); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_op();
        mem_i = 3'b000; wb_i = 2'b10; result_i = 32'h1234; writeaddr_i = 5'd5;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", stall); end
        tick();
        n_tests++; if (wb_o !== 2'b10) begin n_fail++; $display("FAIL alu_wb: got %b want 10", wb_o); end
        n_tests++; if (result_o !== 32'h1234) begin n_fail++; $display("FAIL alu_result: got %h want 1234", result_o); end
        n_tests++; if (writeaddr_o !== 5'd5) begin n_fail++; $display("FAIL alu_waddr: got %0d want 5", writeaddr_o); end
        n_tests++; if (req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL alu_noreq: req=%b stall=%b want 0 0", req, stall); end
    endtask

    task automatic test_load();
        int stall_cnt = 0;
        mem_i = 3'b010; wb_i = 2'b11; result_i = 32'h100; writeaddr_i = 5'd7;
        #1;
        if (stall) stall_cnt++;
        tick();
        n_tests++; if (req !== 1'b1 || we !== 1'b0 || addr !== 32'h100) begin
            n_fail++; $display("FAIL load_req: req=%b we=%b addr=%h want 1 0 100", req, we, addr); end
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (wb_o !== 2'b00) begin n_fail++; $display("FAIL load_bubble%0d: wb=%b want 00", i, wb_o); end
            if (stall) stall_cnt++;
            tick();
        end
        ack = 1'b1; rdata = 32'hDEADBEEF;
        #1;
        if (stall) stall_cnt++;
        n_tests++; if (stall_cnt !== 4) begin n_fail++; $display("FAIL load_stall_cycles: got %0d want 4", stall_cnt); end
        tick();
        ack = 1'b0; mem_i = 3'b000;
        n_tests++; if (memdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_data: got %h want deadbeef", memdata_o); end
        n_tests++; if (wb_o !== 2'b11 || req !== 1'b0) begin n_fail++; $display("FAIL load_done: wb=%b req=%b want 11 0", wb_o, req); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL load_err: got %b want 0", err); end
    endtask

    task automatic test_store();
        mem_i = 3'b001; wb_i = 2'b00; result_i = 32'h204; rtdata_i = 32'hCAFE0001; writeaddr_i = 5'd0;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL store_stall: got %b want 1", stall); end
        tick();
        n_tests++; if (req !== 1'b1 || we !== 1'b1 || addr !== 32'h204 || wdata !== 32'hCAFE0001) begin
            n_fail++; $display("FAIL store_req: req=%b we=%b addr=%h wd=%h want 1 1 204 cafe0001", req, we, addr, wdata); end
        ack = 1'b1; rdata = 32'h11111111;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL store_ack_stall: got %b want 0", stall); end
        tick();
        ack = 1'b0; mem_i = 3'b000;
        n_tests++; if (memdata_o !== 32'hDEADBEEF || err !== 1'b0 || req !== 1'b0) begin
            n_fail++; $display("FAIL store_done: md=%h err=%b req=%b want deadbeef 0 0", memdata_o, err, req); end
    endtask

    task automatic test_ack_idle();
        mem_i = 3'b000; ack = 1'b1; rdata = 32'h55555555;
        tick();
        ack = 1'b0;
        n_tests++; if (memdata_o !== 32'hDEADBEEF || req !== 1'b0) begin
            n_fail++; $display("FAIL ack_idle: md=%h req=%b want deadbeef 0", memdata_o, req); end
    endtask

    task automatic test_errors();
        mem_i = 3'b010; wb_i = 2'b11; result_i = 32'h102; writeaddr_i = 5'd3;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL misal_stall: got %b want 0", stall); end
        tick();
        n_tests++; if (req !== 1'b0 || err !== 1'b1 || wb_o !== 2'b00 || result_o !== 32'h102) begin
            n_fail++; $display("FAIL misal: req=%b err=%b wb=%b res=%h want 0 1 00 102", req, err, wb_o, result_o); end
        mem_i = 3'b011; result_i = 32'h200;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL illegal_stall: got %b want 0", stall); end
        tick();
        n_tests++; if (req !== 1'b0 || err !== 1'b1 || wb_o !== 2'b00) begin
            n_fail++; $display("FAIL illegal: req=%b err=%b wb=%b want 0 1 00", req, err, wb_o); end
        // set wins over a simultaneous clear
        mem_i = 3'b111; err_clr = 1'b1;
        tick();
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set_prio: got %b want 1", err); end
        mem_i = 3'b000;
        tick();
        err_clr = 1'b0;
        n_tests++; if (err !== 1'b0 || wb_o !== 2'b11) begin n_fail++; $display("FAIL err_clear: err=%b wb=%b want 0 11", err, wb_o); end
    endtask

    task automatic test_timeout();
        mem_i = 3'b010; wb_i = 2'b10; result_i = 32'h300; writeaddr_i = 5'd9;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (req !== 1'b1 || stall !== (i < 3)) begin
                n_fail++; $display("FAIL timeout_wait%0d: req=%b stall=%b want 1 %b", i, req, stall, i < 3); end
            tick();
        end
        mem_i = 3'b000;
        n_tests++; if (req !== 1'b0 || err !== 1'b1 || wb_o !== 2'b00) begin
            n_fail++; $display("FAIL timeout_abort: req=%b err=%b wb=%b want 0 1 00", req, err, wb_o); end
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL timeout_stall: got %b want 0", stall); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        // ack on the final permitted cycle completes cleanly
        mem_i = 3'b010; wb_i = 2'b11; result_i = 32'h304;
        tick(); tick(); tick(); tick();
        ack = 1'b1; rdata = 32'hA5A5F00D;
        tick();
        ack = 1'b0; mem_i = 3'b000;
        n_tests++; if (err !== 1'b0 || req !== 1'b0 || memdata_o !== 32'hA5A5F00D || wb_o !== 2'b11) begin
            n_fail++; $display("FAIL timeout_ack_wins: err=%b req=%b md=%h wb=%b want 0 0 a5a5f00d 11", err, req, memdata_o, wb_o); end
    endtask

    task automatic test_back_to_back();
        mem_i = 3'b010; wb_i = 2'b11; result_i = 32'h400;
        tick();
        ack = 1'b1; rdata = 32'h00000400;
        tick();
        ack = 1'b0; result_i = 32'h408;
        #1;
        n_tests++; if (req !== 1'b0 || stall !== 1'b1 || memdata_o !== 32'h400) begin
            n_fail++; $display("FAIL b2b_gap: req=%b stall=%b md=%h want 0 1 400", req, stall, memdata_o); end
        tick();
        n_tests++; if (req !== 1'b1 || addr !== 32'h408) begin n_fail++; $display("FAIL b2b_second: req=%b addr=%h want 1 408", req, addr); end
        ack = 1'b1; rdata = 32'h00000408;
        tick();
        ack = 1'b0; mem_i = 3'b000;
        n_tests++; if (memdata_o !== 32'h408 || req !== 1'b0) begin n_fail++; $display("FAIL b2b_done: md=%h req=%b want 408 0", memdata_o, req); end
    endtask

    task automatic test_reset_mid_access();
        mem_i = 3'b010; wb_i = 2'b11; result_i = 32'h500;
        tick();
        n_tests++; if (req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got %b want 1", req); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: req=%b stall=%b want 0 0", req, stall); end
        n_tests++; if ({wb_o, memdata_o, result_o, writeaddr_o, err} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: wb=%b md=%h res=%h wa=%0d err=%b want all 0",
                              wb_o, memdata_o, result_o, writeaddr_o, err); end
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++; if (stall !== 1'b1 || req !== 1'b0) begin n_fail++; $display("FAIL rst_restart: stall=%b req=%b want 1 0", stall, req); end
        tick();
        ack = 1'b1; rdata = 32'h0BADF00D;
        tick();
        ack = 1'b0; mem_i = 3'b000;
        n_tests++; if (memdata_o !== 32'h0BADF00D || wb_o !== 2'b11 || err !== 1'b0) begin
            n_fail++; $display("FAIL rst_after_load: md=%h wb=%b err=%b want 0badf00d 11 0", memdata_o, wb_o, err); end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_ack_idle();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
